// File: rtl/shift_reg.sv
// shift_reg: parameterised serial-in/serial-out shift register with a
// synchronous parallel load. Used as a serialiser/deserialiser building block.
//
// Parameters
//   WIDTH    register length in bits (2..64)
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset (clears the register)
//   in_bit   serial data in
//   w_data   parallel load value
//   w_en     parallel load enable; has priority over shifting
//   out_bit  serial data out
//   q        parallel view of the register contents
//
// Build option
//   SHIFTREG_LSB_FIRST_EN  when defined, data enters at the MSB, shifts toward
//                          bit 0, and out_bit is bit 0. Load, reset and q are
//                          unchanged. When undefined, data enters at bit 0,
//                          shifts toward the MSB, and out_bit is bit WIDTH-1.

module shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] w_data,
    input  logic             w_en,
    output logic             out_bit,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (w_en) begin
            sr <= w_data;
        end else begin
`ifdef SHIFTREG_LSB_FIRST_EN
            sr <= {in_bit, sr[WIDTH-1:1]};
`else
            sr <= {sr[WIDTH-2:0], in_bit};
`endif
        end
    end

    // Both outputs are taken straight from the register. There is no
    // combinational path from any input.
`ifdef SHIFTREG_LSB_FIRST_EN
    assign out_bit = sr[0];
`else
    assign out_bit = sr[WIDTH-1];
`endif
    assign q = sr;

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: directed steps followed by randomized
// traffic. The reference model treats the register as an unsigned number and
// updates it with plain arithmetic.

module tb_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_bit;
    logic [W-1:0] w_data;
    logic         w_en;
    logic         out_bit;
    logic [W-1:0] q;

    int vectors;
    int miscompares;
    longint unsigned model;

    shift_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_bit (in_bit),
        .w_data (w_data),
        .w_en   (w_en),
        .out_bit(out_bit),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned wmask();
        return (64'd1 << W) - 64'd1;
    endfunction

    // Next register value, computed from the load/shift rules.
    function automatic longint unsigned model_next(longint unsigned cur, logic we,
                                                   longint unsigned wd, logic ib);
        if (we) return wd & wmask();
`ifdef SHIFTREG_LSB_FIRST_EN
        return (cur / 2) + (longint'(ib) * (64'd1 << (W - 1)));
`else
        return ((cur * 2) + longint'(ib)) & wmask();
`endif
    endfunction

    function automatic logic model_out(longint unsigned cur);
`ifdef SHIFTREG_LSB_FIRST_EN
        return cur[0];
`else
        return cur[W-1];
`endif
    endfunction

    task automatic check_q(string tag, logic [W-1:0] exp);
        vectors++;
        assert (q === exp) else begin
            miscompares++;
            $error("FAIL %s: q observed %h expected %h", tag, q, exp);
        end
    endtask

    task automatic check_out(string tag, logic exp);
        vectors++;
        assert (out_bit === exp) else begin
            miscompares++;
            $error("FAIL %s: out_bit observed %b expected %b", tag, out_bit, exp);
        end
    endtask

    // Apply inputs on the falling edge, take the rising edge, then compare
    // both outputs against the model just after the edge.
    task automatic step(string tag, logic we, logic [W-1:0] wd, logic ib);
        @(negedge clk);
        w_en   = we;
        w_data = wd;
        in_bit = ib;
        @(posedge clk);
        #1;
        model = model_next(model, we, longint'(wd), ib);
        check_q(tag, model[W-1:0]);
        check_out(tag, model_out(model));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst    = 1'b0;
        w_en   = 1'b0;
        w_data = '0;
        in_bit = 1'b0;
    endtask

    // Assert reset between edges and check the clear is immediate.
    task automatic async_reset(string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model = 0;
        check_q(tag, '0);
        check_out(tag, 1'b0);
    endtask

    initial begin
        logic [W-1:0] fill_tbl [8];
        logic         out_tbl  [8];
        vectors     = 0;
        miscompares = 0;
        model       = 0;
        rst         = 1'b1;
        w_en        = 1'bx;
        w_data      = 'x;
        in_bit      = 1'bx;

        fill_tbl = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        out_tbl  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset held across edges with X inputs.
        repeat (2) @(posedge clk);
        #1;
        check_q("reset_hold", '0);
        check_out("reset_hold", 1'b0);
        release_reset();

`ifndef SHIFTREG_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) begin
            step("serial_fill", 1'b0, '0, 1'b1);
            check_q("fill_tbl", fill_tbl[i]);
            check_out("fill_out", (i == 7) ? 1'b1 : 1'b0);
        end
        step("load_55", 1'b1, 8'h55, 1'b1);
        check_q("load_55_tbl", 8'h55);
        check_out("load_55_out", 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("shift_out", 1'b0, '0, 1'b0);
            check_out("shift_out_tbl", out_tbl[i]);
        end
        check_q("shift_out_final", 8'h00);
        for (int i = 0; i < 4; i++) begin
            step("load_prio", 1'b1, 8'h55, i[0]);
            check_q("load_prio_tbl", 8'h55);
        end
`else
        step("lsb_load_01", 1'b1, 8'h01, 1'b0);
        step("lsb_shift", 1'b0, 8'h00, 1'b1);
        check_q("lsb_shift_tbl", 8'h80);
        check_out("lsb_shift_out", 1'b0);
`endif

        // Asynchronous clear from 0xA5 with no clock edge.
        step("load_a5", 1'b1, 8'hA5, 1'b0);
        async_reset("async_rst_a5");
        @(negedge clk);
        w_en   = 1'bx;
        w_data = 'x;
        in_bit = 1'bx;
        @(posedge clk);
        #1;
        check_q("rst_x_inputs", '0);
        release_reset();

        // Randomized traffic, with an occasional mid-cycle reset.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rand_rst");
                release_reset();
            end else begin
                step("random", ($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
